// File: rtl/dadda_mac16_if.sv
// rtl/dadda_mac16_if.sv - operand/result handshake bundle for dadda_mac16
// Purpose: groups the operand stream, the frame result stream and clear.
// Signals:
//   clear                 synchronous abort of the frame in progress
//   in_valid/in_ready     operand pair handshake; A, B operands; in_last closes the frame
//   out_valid/out_ready   frame result handshake; Y sum, ovf wrap flag, cnt pair count
// Modports: master drives operands and consumes results; slave is the MAC.
interface dadda_mac16_if #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
);
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      A;
  logic [15:0]      B;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] Y;
  logic             ovf;
  logic [CNT_W-1:0] cnt;

  modport master (
    output clear, in_valid, A, B, in_last, out_ready,
    input  in_ready, out_valid, Y, ovf, cnt
  );

  modport slave (
    input  clear, in_valid, A, B, in_last, out_ready,
    output in_ready, out_valid, Y, ovf, cnt
  );
endinterface

// File: rtl/dadda_mac16.sv
// rtl/dadda_mac16.sv - frame multiply-accumulate around a 16x16 Dadda multiplier
// Purpose: registers operand pairs, multiplies them with dadda_16 and sums the
// products of each frame; the frame total is presented on a valid/ready output.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   dadda_mac16_if.slave (operand stream in, frame result out, clear)

// dadda_16: combinational unsigned 16x16 multiplier. Partial products are
// reduced column by column through the Dadda height sequence 13,9,6,4,3,2
// and the final two rows are summed with a carry-propagate adder.
module dadda_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  logic [31:0][31:0] col;
  logic [31:0][31:0] nxt;
  int                h  [32];
  int                nh [32];
  int                d;
  int                idx;
  int                r;
  logic [31:0]       row0;
  logic [31:0]       row1;

  function automatic int stage_limit(input int s);
    case (s)
      0:       return 13;
      1:       return 9;
      2:       return 6;
      3:       return 4;
      4:       return 3;
      default: return 2;
    endcase
  endfunction

  always_comb begin
    col  = '0;
    nxt  = '0;
    d    = 0;
    idx  = 0;
    r    = 0;
    row0 = '0;
    row1 = '0;
    for (int c = 0; c < 32; c++) begin
      h[c]  = 0;
      nh[c] = 0;
    end
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        col[i+j][h[i+j]] = a[i] & b[j];
        h[i+j] = h[i+j] + 1;
      end
    end
    for (int s = 0; s < 6; s++) begin
      d   = stage_limit(s);
      nxt = '0;
      for (int c = 0; c < 32; c++) nh[c] = 0;
      for (int c = 0; c < 32; c++) begin
        idx = 0;
        // Carries already landed in nh[c] from column c-1 count toward the
        // target height, so only reduce while the column would exceed d.
        for (int k = 0; k < 16; k++) begin
          r = h[c] - idx + nh[c];
          if (r > d) begin
            if ((r - d >= 2) && (h[c] - idx >= 3)) begin
              nxt[c][nh[c]] = col[c][idx] ^ col[c][idx+1] ^ col[c][idx+2];
              if (c < 31) begin
                nxt[c+1][nh[c+1]] = (col[c][idx] & col[c][idx+1]) |
                                    (col[c][idx] & col[c][idx+2]) |
                                    (col[c][idx+1] & col[c][idx+2]);
                nh[c+1] = nh[c+1] + 1;
              end
              nh[c] = nh[c] + 1;
              idx   = idx + 3;
            end else if (h[c] - idx >= 2) begin
              nxt[c][nh[c]] = col[c][idx] ^ col[c][idx+1];
              if (c < 31) begin
                nxt[c+1][nh[c+1]] = col[c][idx] & col[c][idx+1];
                nh[c+1] = nh[c+1] + 1;
              end
              nh[c] = nh[c] + 1;
              idx   = idx + 2;
            end
          end
        end
        for (int k = 0; k < 16; k++) begin
          if (idx < h[c]) begin
            nxt[c][nh[c]] = col[c][idx];
            nh[c] = nh[c] + 1;
            idx   = idx + 1;
          end
        end
      end
      col = nxt;
      for (int c = 0; c < 32; c++) h[c] = nh[c];
    end
    for (int c = 0; c < 32; c++) begin
      row0[c] = col[c][0];
      row1[c] = col[c][1];
    end
    p = row0 + row1;
  end
endmodule

module dadda_mac16 #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  dadda_mac16_if.slave  bus
);
  typedef enum logic {EMPTY, ACCUM} state_t;

  state_t           state;
  logic [15:0]      a_r;
  logic [15:0]      b_r;
  logic             last_r;
  logic             v1;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] fcnt;
  logic             fovf;
  logic             out_valid_r;
  logic [ACC_W-1:0] y_r;
  logic             ovf_r;
  logic [CNT_W-1:0] cnt_r;

  logic [31:0]      prod;
  logic             stall;
  logic             accept;
  logic             fire;
  logic             emit;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] n_acc;
  logic             n_fovf;
  logic [CNT_W-1:0] n_fcnt;

  dadda_16 u_mul (.a(a_r), .b(b_r), .p(prod));

  assign stall         = out_valid_r & ~bus.out_ready;
  assign bus.in_ready  = ~stall & ~bus.clear;
  assign accept        = bus.in_valid & bus.in_ready;
  assign fire          = v1 & ~stall & ~bus.clear;
  assign emit          = fire & last_r;
  assign bus.out_valid = out_valid_r;
  assign bus.Y         = y_r;
  assign bus.ovf       = ovf_r;
  assign bus.cnt       = cnt_r;

  // Post-update frame state; the emitted result is taken from these values.
  always_comb begin
    sum_ext = {1'b0, acc} + (ACC_W+1)'(prod);
    n_acc   = ACC_W'(prod);
    n_fovf  = 1'b0;
    n_fcnt  = CNT_W'(1);
    if (state == ACCUM) begin
      n_acc  = sum_ext[ACC_W-1:0];
      n_fovf = fovf | sum_ext[ACC_W];
      n_fcnt = (fcnt == '1) ? fcnt : fcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      a_r         <= '0;
      b_r         <= '0;
      last_r      <= 1'b0;
      v1          <= 1'b0;
      acc         <= '0;
      fcnt        <= '0;
      fovf        <= 1'b0;
      out_valid_r <= 1'b0;
      y_r         <= '0;
      ovf_r       <= 1'b0;
      cnt_r       <= '0;
    end else begin
      // The output register keeps running through clear so a pending
      // result still completes its handshake.
      if (emit) begin
        out_valid_r <= 1'b1;
        y_r         <= n_acc;
        ovf_r       <= n_fovf;
        cnt_r       <= n_fcnt;
      end else if (out_valid_r && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end

      if (bus.clear) begin
        v1    <= 1'b0;
        state <= EMPTY;
        acc   <= '0;
        fcnt  <= '0;
        fovf  <= 1'b0;
      end else begin
        if (accept) begin
          a_r    <= bus.A;
          b_r    <= bus.B;
          last_r <= bus.in_last;
          v1     <= 1'b1;
        end else if (!stall) begin
          v1 <= 1'b0;
        end
        if (fire) begin
          acc   <= n_acc;
          fovf  <= n_fovf;
          fcnt  <= n_fcnt;
          state <= last_r ? EMPTY : ACCUM;
        end
      end
    end
  end
endmodule

// File: tb/tb_dadda_mac16.sv
// tb/tb_dadda_mac16.sv - self-checking bench for dadda_mac16
module tb_dadda_mac16;
  localparam int ACC_W = 40;
  localparam int CNT_W = 8;

  typedef struct {
    logic [ACC_W-1:0] y;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dadda_mac16_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();
  dadda_mac16 #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: frame totals built from accepted pairs with plain arithmetic.
  res_t             q[$];
  logic [63:0]      fsum = 0;
  int               fpairs = 0;
  logic             stall_prev = 0;
  logic [ACC_W-1:0] y_prev = 0;

  always @(negedge clk) begin : mon
    res_t r;
    if (rst) begin
      q.delete();
      fsum       = 0;
      fpairs     = 0;
      stall_prev = 0;
    end else begin
      if (stall_prev) check("hold_y", bus.Y, y_prev);
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) check("spurious_out", 1, 0);
        else begin
          r = q.pop_front();
          check("mdl_y", bus.Y, r.y);
          check("mdl_ovf", bus.ovf, r.ovf);
          check("mdl_cnt", bus.cnt, r.cnt);
        end
      end
      if (bus.clear) begin
        fsum   = 0;
        fpairs = 0;
      end else if (bus.in_valid && bus.in_ready) begin
        fsum   = fsum + 64'(bus.A) * 64'(bus.B);
        fpairs = fpairs + 1;
        if (bus.in_last) begin
          r.y   = fsum[ACC_W-1:0];
          r.ovf = (fsum >> ACC_W) != 0;
          r.cnt = (fpairs > (1 << CNT_W) - 1) ? CNT_W'((1 << CNT_W) - 1) : CNT_W'(fpairs);
          q.push_back(r);
          fsum   = 0;
          fpairs = 0;
        end
      end
      stall_prev = bus.out_valid & ~bus.out_ready;
      y_prev     = bus.Y;
    end
  end

  // Called and returns at posedge+1; returns just after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
    int n;
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.in_last  = last;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [ACC_W-1:0] y,
                            input logic o, input logic [CNT_W-1:0] c);
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_seen"}, n < 20, 1);
    check({tag, "_y"}, bus.Y, y);
    check({tag, "_ovf"}, bus.ovf, o);
    check({tag, "_cnt"}, bus.cnt, c);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_y", bus.Y, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_cnt", bus.cnt, 0);
    rst = 1'b0;
    #1;
    check("rst_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Two-pair frame and latency
    send(16'd3, 16'd4, 1'b0);
    send(16'd5, 16'd6, 1'b1);
    check("t1_lat_early", bus.out_valid, 0);
    @(posedge clk);
    #1;
    check("t1_valid", bus.out_valid, 1);
    check("t1_y", bus.Y, 42);
    check("t1_cnt", bus.cnt, 2);
    check("t1_ovf", bus.ovf, 0);
    @(posedge clk);
    #1;
    check("t1_pulse", bus.out_valid, 0);

    // Max operands: saturated count, then accumulator wrap
    for (int i = 0; i < 256; i++) send(16'hFFFF, 16'hFFFF, i == 255);
    expect_out("max256", 40'hFFFE000100, 1'b0, 8'd255);
    for (int i = 0; i < 257; i++) send(16'hFFFF, 16'hFFFF, i == 256);
    expect_out("max257", 40'h00FDFE0101, 1'b1, 8'd255);

    // Backpressure
    bus.out_ready = 1'b0;
    send(16'd2, 16'd2, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("bp_valid", bus.out_valid, 1);
    check("bp_y", bus.Y, 4);
    check("bp_ready", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    bus.A        = 16'd1;
    bus.B        = 16'd1;
    bus.in_last  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("bp_hold_y", bus.Y, 4);
    check("bp_hold_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("bp_drop", bus.out_valid, 0);
    expect_out("bp2", 40'd1, 1'b0, 8'd1);

    // Back-to-back single-pair frames
    send(16'd7, 16'd7, 1'b1);
    send(16'd8, 16'd8, 1'b1);
    check("b2b_v1", bus.out_valid, 1);
    check("b2b_49", bus.Y, 49);
    send(16'd9, 16'd9, 1'b1);
    check("b2b_v2", bus.out_valid, 1);
    check("b2b_64", bus.Y, 64);
    @(posedge clk);
    #1;
    check("b2b_v3", bus.out_valid, 1);
    check("b2b_81", bus.Y, 81);
    check("b2b_cnt", bus.cnt, 1);
    @(posedge clk);
    #1;
    check("b2b_end", bus.out_valid, 0);

    // Clear drops the partial frame; a pair offered during clear is refused
    send(16'd10, 16'd10, 1'b0);
    send(16'd20, 16'd20, 1'b0);
    bus.clear    = 1'b1;
    bus.in_valid = 1'b1;
    bus.A        = 16'd9;
    bus.B        = 16'd9;
    bus.in_last  = 1'b1;
    #1;
    check("clr_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    send(16'd1, 16'd2, 1'b1);
    expect_out("clr", 40'd2, 1'b0, 8'd1);

    // Clear leaves a pending result intact
    bus.out_ready = 1'b0;
    send(16'd5, 16'd5, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    check("clr_pend_valid", bus.out_valid, 1);
    check("clr_pend_y", bus.Y, 25);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("clr_pend_done", bus.out_valid, 0);

    // Asynchronous reset mid-frame
    send(16'd100, 16'd100, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_y", bus.Y, 0);
    check("arst_cnt", bus.cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(16'd3, 16'd3, 1'b1);
    expect_out("arst_next", 40'd9, 1'b0, 8'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.A         = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      bus.B         = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      bus.in_last   = ($urandom_range(0, 3) == 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b1;
    bus.A         = 16'd1;
    bus.B         = 16'd1;
    bus.in_last   = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("drain_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dadda_mac16.md
Name: dadda_mac16

Overview:
Multiply-accumulate stage placed directly downstream of the 16x16 Dadda multiplier. It registers operand pairs and instantiates dadda_16 on the registered operands. Each 32-bit product is accumulated into a frame-wide accumulator. When the sample flagged last arrives, the frame total is presented on a valid/ready output. Typical use is the dot-product or FIR tap-sum path.

Parameters:
ACC_W  40  accumulator and result width; must be at least 32; the product is zero-extended to ACC_W.
CNT_W  8   width of the per-frame sample counter; the counter saturates.

Ports:
clk        input   1       rising-edge clock.
rst        input   1       asynchronous, active-high reset.
clear      input   1       synchronous abort of the frame in progress.
in_valid   input   1       operand pair valid.
in_ready   output  1       block can accept an operand pair.
A          input   16      unsigned multiplicand.
B          input   16      unsigned multiplier.
in_last    input   1       this pair closes the frame.
out_valid  output  1       frame result valid.
out_ready  input   1       consumer accepts the result.
Y          output  ACC_W   frame sum of A*B, modulo 2^ACC_W.
ovf        output  1       the frame sum exceeded 2^ACC_W - 1.
cnt        output  CNT_W   number of pairs in the frame, saturating at 2^CNT_W - 1.

Behaviour:
- Reset (clk and rst are the only clock and reset, per "Already decided"):
  - All registers clear asynchronously.
  - out_valid=0, Y=0, ovf=0, cnt=0.
  - in_ready=1 once rst is deasserted.
- Stall and handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall & ~clear.
  - A pair is accepted on a rising edge where in_valid & in_ready.
- Stage 1 (operand registers):
  - On acceptance, A_r, B_r and last_r load, and v1 is set to 1.
  - Else, if ~stall, v1 is set to 0.
  - While stall, stage 1 holds its contents.
- Product:
  - P = dadda_16(A_r, B_r), combinational, 32 bits.
  - No product register.
- Frame state machine, with states EMPTY and ACCUM:
  - EMPTY, v1 & ~stall:
    - acc <= P; fcnt <= 1; fovf <= 0.
    - If last_r, the result is emitted and the state stays EMPTY.
    - Otherwise the state moves to ACCUM.
  - ACCUM, v1 & ~stall:
    - {carry, acc} <= acc + P.
    - fovf <= fovf | carry.
    - fcnt <= sat(fcnt + 1).
    - If last_r, the result is emitted and the state moves to EMPTY.
  - Emit means: Y <= the post-update acc; ovf <= the post-update fovf; cnt <= the post-update fcnt; out_valid <= 1.
  - The single-sample frame is legal: Y=P, cnt=1.
- Output register:
  - out_valid clears on out_valid & out_ready, unless an emit occurs in the same cycle; in that case the new result loads and out_valid stays 1 (back-to-back frames run at full rate).
  - Y, ovf and cnt are stable while out_valid & ~out_ready.
- Latency: the last pair is accepted at edge k, and out_valid=1 after edge k+1 (2 cycles from the in_valid/in_ready handshake).
- Throughput: one pair per cycle when out_ready=1.
- clear (synchronous, highest priority after rst):
  - Next edge: v1=0, state=EMPTY, acc=0, fcnt=0, fovf=0.
  - in_ready=0 during clear, so no pair is accepted that cycle.
  - The output register, out_valid, Y, ovf and cnt are untouched; a pending result still completes its handshake.
- Arithmetic:
  - Unsigned throughout.
  - The accumulator wraps modulo 2^ACC_W; ovf records any wrap within the frame.
  - fcnt saturates at 2^CNT_W - 1 and does not wrap.
- Mid-operation reset: rst at any time drops the partial frame and any pending result with no output handshake.
- Frame boundary: the pair after a last pair always starts a fresh frame, including when it is accepted in the cycle the result emits.

Test Plan:
- Two-pair frame: (3,4) then (5,6,last) on consecutive cycles, out_ready=1 -> out_valid pulses 2 cycles after the second accept; Y=42, cnt=2, ovf=0.
- Max operands: 256 pairs of (0xFFFF,0xFFFF), last on the 256th -> Y=0xFFFE000100, cnt=255 (saturated), ovf=0. The same stream with 257 pairs -> Y=0x00FDFE0101, ovf=1, cnt=255.
- Backpressure: frame (2,2,last) with out_ready=0 -> Y=4 held and in_ready=0 while stalled. Then send (1,1,last) with out_ready raised after 5 cycles -> Y=4 handshakes, then Y=1 follows with no lost or duplicated frame.
- Back-to-back frames: (7,7,last), (8,8,last), (9,9,last) on consecutive cycles, out_ready=1 -> out_valid is high 3 consecutive cycles with Y=49, 64, 81 and cnt=1 each.
- Clear: accept (10,10) and (20,20), assert clear 1 cycle, then send (1,2,last) -> Y=2, cnt=1. A pending unaccepted result from before the clear is preserved.
- Reset mid-frame: accept (100,100), pulse rst asynchronously between edges -> out_valid=0, Y=0 immediately. The next frame (3,3,last) -> Y=9, cnt=1.
